// File: rtl/regfile_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Address width for a given depth; never below one bit.
    function automatic int rf_aw(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear engine: sweeps every entry once after reset or on a clear request.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = rf_aw(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr_req,
    output logic          o_busy,
    output logic          o_clr_we,
    output logic [AW-1:0] o_clr_addr,
    output rf_state_t     o_state
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t     r_state;
    logic [AW-1:0] r_cnt;
    logic          r_busy;

    // The counter parks on the last entry instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RF_CLEAR;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                RF_IDLE: begin
                    if (i_clr_req) begin
                        r_state <= RF_CLEAR;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (r_cnt == LAST) begin
                        r_state <= RF_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= RF_CLEAR;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_clr_we   = r_busy;
    assign o_clr_addr = r_cnt;
    assign o_state    = r_state;

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write bypass, optional hard-wired x0 and a
// per-register pending scoreboard for the hazard unit.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = 32,
    parameter  int DEPTH    = 32,
    parameter  int NREAD    = 2,
    parameter  int ZERO_REG = 1,
    localparam int AW       = rf_aw(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREAD*AW-1:0]    ra,
    output logic [NREAD*WIDTH-1:0] rd,
    output logic [NREAD-1:0]       rd_pend,
    input  logic                   we,
    input  logic [AW-1:0]          wa,
    input  logic [WIDTH-1:0]       wd,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_addr,
    input  logic                   clr_req,
    output logic                   busy
);

    logic             w_busy;
    logic             w_clr_we;
    logic [AW-1:0]    w_clr_addr;
    rf_state_t        w_state;
    logic             w_idle;
    logic             w_wr_en;
    logic             w_iss_ok;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_nxt;

    regfile_clear_fsm #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_clear (
        .clk        (clk),
        .rst        (rst),
        .i_clr_req  (clr_req),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr),
        .o_state    (w_state)
    );

    assign w_idle   = (w_state == RF_IDLE);
    assign w_wr_en  = w_idle && we && !((ZERO_REG != 0) && (wa == '0));
    assign w_iss_ok = w_idle && iss_en && !((ZERO_REG != 0) && (iss_addr == '0));
    assign busy     = w_busy;

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_mem[wa] <= wd;
        end
    end

    // Issue is applied after writeback so a same-cycle set beats the clear.
    always_comb begin
        w_pend_nxt = r_pend;
        if (w_idle && we) begin
            w_pend_nxt[wa] = 1'b0;
        end
        if (w_iss_ok) begin
            w_pend_nxt[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            w_pend_nxt[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= '0;
        end else if (w_clr_we) begin
            r_pend[w_clr_addr] <= 1'b0;
        end else if (w_idle) begin
            r_pend <= w_pend_nxt;
        end
    end

    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
        logic [AW-1:0] w_ra;
        logic          w_ra_zero;
        logic          w_byp;

        assign w_ra      = ra[gi*AW +: AW];
        assign w_ra_zero = (ZERO_REG != 0) && (w_ra == '0);
        assign w_byp     = we && (wa == w_ra);

        assign rd[gi*WIDTH +: WIDTH] = (w_busy || w_ra_zero) ? '0 :
                                       w_byp                 ? wd : r_mem[w_ra];
        assign rd_pend[gi] = !w_busy && r_pend[w_ra] && !w_byp;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two configurations (32x32/2 ports and 16x32/4 ports)
// checked every cycle against a behavioural model, plus directed literal checks.
module tb_regfile_sb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus signals ----------------
    logic        we       = 1'b0;
    logic        iss_en   = 1'b0;
    logic        clr_req  = 1'b0;
    logic [4:0]  wa       = '0;
    logic [4:0]  iss_addr = '0;
    logic [31:0] wd       = '0;
    logic [4:0]  ra_v [4];
    logic [9:0]  ra_a;
    logic [15:0] ra_b;

    logic [63:0]  rd_a;
    logic [127:0] rd_b;
    logic [1:0]   pend_a;
    logic [3:0]   pend_b;
    logic         busy_a;
    logic         busy_b;

    always_comb begin
        ra_a = {ra_v[1], ra_v[0]};
        ra_b = {ra_v[3][3:0], ra_v[2][3:0], ra_v[1][3:0], ra_v[0][3:0]};
    end

    regfile_sb #(.WIDTH(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .ra       (ra_a),
        .rd       (rd_a),
        .rd_pend  (pend_a),
        .we       (we),
        .wa       (wa),
        .wd       (wd),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .clr_req  (clr_req),
        .busy     (busy_a)
    );

    regfile_sb #(.WIDTH(32), .DEPTH(16), .NREAD(4), .ZERO_REG(1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .ra       (ra_b),
        .rd       (rd_b),
        .rd_pend  (pend_b),
        .we       (we),
        .wa       (wa[3:0]),
        .wd       (wd),
        .iss_en   (iss_en),
        .iss_addr (iss_addr[3:0]),
        .clr_req  (clr_req),
        .busy     (busy_b)
    );

    // ---------------- scoreboard counters ----------------
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int k, input int p,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s inst=%0d port=%0d actual=%h required=%h", nm, k, p, act, exp);
        end
    endtask

    function automatic int dep(input int k);
        return (k == 0) ? 32 : 16;
    endfunction

    function automatic int nrd(input int k);
        return (k == 0) ? 2 : 4;
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_mem  [2][32];
    bit          m_pend [2][32];
    int          m_busy_left [2] = '{32, 16};

    task automatic wipe(input int k);
        for (int r = 0; r < 32; r++) begin
            m_mem[k][r]  = '0;
            m_pend[k][r] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [4:0] msk;
            logic [4:0] a_w;
            logic [4:0] a_i;
            msk = 5'(dep(k) - 1);
            a_w = wa & msk;
            a_i = iss_addr & msk;
            if (!rst) begin
                m_busy_left[k] = dep(k);
                wipe(k);
            end else if (m_busy_left[k] > 0) begin
                m_busy_left[k]--;
            end else if (clr_req) begin
                m_busy_left[k] = dep(k);
                wipe(k);
            end else begin
                if (we && a_w != 0) m_mem[k][a_w] = wd;
                if (we) m_pend[k][a_w] = 1'b0;
                if (iss_en && a_i != 0) m_pend[k][a_i] = 1'b1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic        exp_busy;
            logic [4:0]  msk;
            logic [4:0]  a;
            logic [31:0] exp_rd;
            logic        exp_p;
            logic [31:0] act_rd;
            logic        act_p;
            msk      = 5'(dep(k) - 1);
            exp_busy = !rst || (m_busy_left[k] > 0);
            chk("busy", k, 0, {31'd0, (k == 0) ? busy_a : busy_b}, {31'd0, exp_busy});
            for (int i = 0; i < nrd(k); i++) begin
                a = ra_v[i] & msk;
                if (exp_busy || a == 0) begin
                    exp_rd = '0;
                    exp_p  = 1'b0;
                end else if (we && (wa & msk) == a) begin
                    exp_rd = wd;
                    exp_p  = 1'b0;
                end else begin
                    exp_rd = m_mem[k][a];
                    exp_p  = m_pend[k][a];
                end
                act_rd = (k == 0) ? rd_a[i*32 +: 32] : rd_b[i*32 +: 32];
                act_p  = (k == 0) ? pend_a[i] : pend_b[i];
                chk("rd", k, i, act_rd, exp_rd);
                chk("rd_pend", k, i, {31'd0, act_p}, {31'd0, exp_p});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        we      = 1'b0;
        iss_en  = 1'b0;
        clr_req = 1'b0;
    endtask

    // Counts busy cycles over a bounded window with idle inputs.
    task automatic count_busy(output int na, output int nb);
        na = 0;
        nb = 0;
        for (int j = 0; j < 50; j++) begin
            settle();
            if (busy_a) na++;
            if (busy_b) nb++;
            tick();
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int na;
        int nb;
        for (int i = 0; i < 4; i++) ra_v[i] = '0;

        // reset and initial sweep
        repeat (3) tick();
        settle();
        chk("rst_busy", 0, 0, {31'd0, busy_a}, 32'd1);
        chk("rst_busy", 1, 0, {31'd0, busy_b}, 32'd1);
        tick();
        rst = 1'b1;
        count_busy(na, nb);
        chk("busy_len_rst", 0, 0, na, 32'd32);
        chk("busy_len_rst", 1, 0, nb, 32'd16);

        ra_v[0] = 5'd5;
        ra_v[1] = 5'd31;
        settle();
        chk("lit_zero_after_clear", 0, 0, rd_a[31:0], 32'd0);
        chk("lit_zero_after_clear", 0, 1, rd_a[63:32], 32'd0);
        tick();

        // bypass then stored value
        we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra_v[0] = 5'd5;
        settle();
        chk("lit_bypass", 0, 0, rd_a[31:0], 32'hDEADBEEF);
        chk("lit_bypass", 1, 0, rd_b[31:0], 32'hDEADBEEF);
        tick();
        we = 1'b0;
        settle();
        chk("lit_stored", 0, 0, rd_a[31:0], 32'hDEADBEEF);
        tick();

        // x0 hard-wired
        we = 1'b1; wa = 5'd0; wd = 32'h1234; ra_v[0] = 5'd0;
        settle();
        chk("lit_x0_bypass", 0, 0, rd_a[31:0], 32'd0);
        tick();
        we = 1'b0; iss_en = 1'b1; iss_addr = 5'd0; ra_v[1] = 5'd0;
        tick();
        iss_en = 1'b0;
        settle();
        chk("lit_x0_pend", 0, 1, {31'd0, pend_a[1]}, 32'd0);
        chk("lit_x0_read", 0, 1, rd_a[63:32], 32'd0);
        tick();

        // scoreboard set / clear / set-wins
        iss_en = 1'b1; iss_addr = 5'd7;
        tick();
        iss_en = 1'b0; ra_v[0] = 5'd7;
        settle();
        chk("lit_pend_set", 0, 0, {31'd0, pend_a[0]}, 32'd1);
        tick();
        we = 1'b1; wa = 5'd7; wd = 32'd77;
        settle();
        chk("lit_pend_fwd", 0, 0, {31'd0, pend_a[0]}, 32'd0);
        chk("lit_wb_bypass", 0, 0, rd_a[31:0], 32'd77);
        tick();
        we = 1'b0;
        settle();
        chk("lit_pend_cleared", 0, 0, {31'd0, pend_a[0]}, 32'd0);
        tick();
        iss_en = 1'b1; iss_addr = 5'd7; we = 1'b1; wa = 5'd7; wd = 32'd88;
        tick();
        idle_inputs();
        settle();
        chk("lit_set_wins", 0, 0, {31'd0, pend_a[0]}, 32'd1);
        chk("lit_set_wins_data", 0, 0, rd_a[31:0], 32'd88);
        tick();

        // clear request; activity and a second request during the sweep are ignored
        we = 1'b1; wa = 5'd3; wd = 32'hA5;
        tick();
        we = 1'b0; clr_req = 1'b1;
        tick();
        na = 0;
        for (int j = 1; j <= 60; j++) begin
            we = 1'b1; wa = 5'd3; wd = 32'hFF;
            iss_en = 1'b1; iss_addr = 5'd3;
            clr_req = (j == 10);
            settle();
            if (!busy_a) begin
                idle_inputs();
                break;
            end
            na++;
            tick();
        end
        chk("busy_len_clr", 0, 0, na, 32'd32);
        tick();
        ra_v[0] = 5'd3;
        settle();
        chk("lit_x3_cleared", 0, 0, rd_a[31:0], 32'd0);
        chk("lit_x3_not_pend", 0, 0, {31'd0, pend_a[0]}, 32'd0);
        tick();

        // reset in the middle of a sweep restarts it
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (14) tick();
        rst = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        count_busy(na, nb);
        chk("busy_len_midrst", 0, 0, na, 32'd32);
        chk("busy_len_midrst", 1, 0, nb, 32'd16);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            we       = 1'($urandom_range(0, 1));
            wa       = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wd       = $urandom;
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            clr_req  = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < 4; i++) begin
                ra_v[i] = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            end
            tick();
        end
        idle_inputs();
        settle();
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
